// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared types for the reservation station slice
package reservation_station_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;

    typedef enum logic [1:0] {
        OPA_IS_RS1  = 2'h0,
        OPA_IS_NPC  = 2'h1,
        OPA_IS_PC   = 2'h2,
        OPA_IS_ZERO = 2'h3
    } ALU_OPA_SELECT;

    typedef enum logic [2:0] {
        OPB_IS_RS2   = 3'h0,
        OPB_IS_I_IMM = 3'h1,
        OPB_IS_S_IMM = 3'h2,
        OPB_IS_B_IMM = 3'h3,
        OPB_IS_U_IMM = 3'h4,
        OPB_IS_J_IMM = 3'h5
    } ALU_OPB_SELECT;

    typedef struct packed {
        logic [XLEN-1:0] NPC;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        ALU_OPA_SELECT   opa_select;
        ALU_OPB_SELECT   opb_select;
        logic [31:0]     inst;
        logic [4:0]      dest_reg_idx;
        logic [4:0]      alu_func;
        logic            rd_mem;
        logic            wr_mem;
        logic            cond_branch;
        logic            uncond_branch;
        logic            halt;
        logic            illegal;
        logic            valid;
    } ID_EX_PACKET;

    // One waiting instruction: its packet, destination tag and per-operand state.
    typedef struct packed {
        logic                   busy;
        ID_EX_PACKET            packet;
        logic [ROB_TAG_LEN-1:0] dest_tag;
        logic [ROB_TAG_LEN-1:0] rs1_tag;
        logic [ROB_TAG_LEN-1:0] rs2_tag;
        logic [XLEN-1:0]        rs1_value;
        logic [XLEN-1:0]        rs2_value;
        logic                   rs1_ready;
        logic                   rs2_ready;
    } RS_ENTRY;

    // Stores read rs2 as data and branches compare both registers.
    function automatic logic needs_rs1(input ID_EX_PACKET p);
        return (p.opa_select == OPA_IS_RS1) || p.cond_branch || p.wr_mem;
    endfunction

    function automatic logic needs_rs2(input ID_EX_PACKET p);
        return (p.opb_select == OPB_IS_RS2) || p.cond_branch || p.wr_mem;
    endfunction

endpackage

// File: rtl/rs_psel.sv
// rtl/rs_psel.sv - lowest-index priority encoder
module rs_psel #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set request wins the last write.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - operand-waiting buffer with in-order-by-index dispatch
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash,
    input  logic                           alloc_enable,
    input  ID_EX_PACKET                    id_packet_in,
    input  logic [ROB_TAG_LEN-1:0]         alloc_rob_tag,
    input  logic [ROB_TAG_LEN-1:0]         rs1_rob_tag,
    input  logic [ROB_TAG_LEN-1:0]         rs2_rob_tag,
    input  logic                           cdb_valid,
    input  logic [ROB_TAG_LEN-1:0]         cdb_rob_tag,
    input  logic [XLEN-1:0]                cdb_value,
    input  logic                           fu_ready,
    output logic                           rs_full,
    output logic [$clog2(RS_SIZE+1)-1:0]   free_count,
    output logic                           issue_valid,
    output ID_EX_PACKET                    issue_packet,
    output logic [ROB_TAG_LEN-1:0]         issue_rob_tag
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    RS_ENTRY entries_q [RS_SIZE];
    RS_ENTRY entries_d [RS_SIZE];

    logic [RS_SIZE-1:0] free_req;
    logic [RS_SIZE-1:0] ready_req;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               rdy_found;
    logic [IDX_W-1:0]   rdy_idx;
    logic               alloc_fire;
    logic               disp_fire;
    RS_ENTRY            new_entry;

    // Request vectors for the free-slot and ready-slot searches.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_req[i]  = ~entries_q[i].busy;
            ready_req[i] = entries_q[i].busy & entries_q[i].rs1_ready & entries_q[i].rs2_ready;
        end
    end

    rs_psel #(.WIDTH(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
        .req   (free_req),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_psel #(.WIDTH(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
        .req   (ready_req),
        .found (rdy_found),
        .idx   (rdy_idx)
    );

    assign rs_full     = ~free_found;
    assign issue_valid = rdy_found;
    assign alloc_fire  = alloc_enable & id_packet_in.valid & free_found;
    assign disp_fire   = rdy_found & fu_ready;

    // Count non-busy entries from registered state only.
    always_comb begin
        free_count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!entries_q[i].busy) begin
                free_count = free_count + CNT_W'(1);
            end
        end
    end

    // Present the selected entry with its captured operand values; zero when idle.
    always_comb begin
        issue_packet  = '0;
        issue_rob_tag = '0;
        if (rdy_found) begin
            issue_packet           = entries_q[rdy_idx].packet;
            issue_packet.rs1_value = entries_q[rdy_idx].rs1_value;
            issue_packet.rs2_value = entries_q[rdy_idx].rs2_value;
            issue_rob_tag          = entries_q[rdy_idx].dest_tag;
        end
    end

    // Build the incoming entry, resolving operands from the packet or a same-cycle CDB hit.
    always_comb begin
        new_entry           = '0;
        new_entry.busy      = 1'b1;
        new_entry.packet    = id_packet_in;
        new_entry.dest_tag  = alloc_rob_tag;
        new_entry.rs1_tag   = rs1_rob_tag;
        new_entry.rs2_tag   = rs2_rob_tag;
        new_entry.rs1_value = id_packet_in.rs1_value;
        new_entry.rs2_value = id_packet_in.rs2_value;
        if (!needs_rs1(id_packet_in) || rs1_rob_tag == '0) begin
            new_entry.rs1_ready = 1'b1;
        end else if (cdb_valid && cdb_rob_tag == rs1_rob_tag) begin
            new_entry.rs1_ready = 1'b1;
            new_entry.rs1_value = cdb_value;
        end
        if (!needs_rs2(id_packet_in) || rs2_rob_tag == '0) begin
            new_entry.rs2_ready = 1'b1;
        end else if (cdb_valid && cdb_rob_tag == rs2_rob_tag) begin
            new_entry.rs2_ready = 1'b1;
            new_entry.rs2_value = cdb_value;
        end
    end

    // Next state: wakeup, then dispatch release, then allocation; squash clears everything.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].busy && cdb_valid) begin
                if (!entries_q[i].rs1_ready && entries_q[i].rs1_tag == cdb_rob_tag) begin
                    entries_d[i].rs1_ready = 1'b1;
                    entries_d[i].rs1_value = cdb_value;
                end
                if (!entries_q[i].rs2_ready && entries_q[i].rs2_tag == cdb_rob_tag) begin
                    entries_d[i].rs2_ready = 1'b1;
                    entries_d[i].rs2_value = cdb_value;
                end
            end
        end
        if (disp_fire) begin
            entries_d[rdy_idx].busy = 1'b0;
        end
        // The free slot is never the dispatching slot, so the two writes cannot collide.
        if (alloc_fire) begin
            entries_d[free_idx] = new_entry;
        end
        if (squash) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_d[i].busy = 1'b0;
            end
        end
    end

    // Entry storage register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - self-checking bench for reservation_station
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int RS = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   squash;
    logic                   alloc_enable;
    ID_EX_PACKET            id_packet_in;
    logic [ROB_TAG_LEN-1:0] alloc_rob_tag;
    logic [ROB_TAG_LEN-1:0] rs1_rob_tag;
    logic [ROB_TAG_LEN-1:0] rs2_rob_tag;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_rob_tag;
    logic [XLEN-1:0]        cdb_value;
    logic                   fu_ready;
    logic                   rs_full;
    logic [3:0]             free_count;
    logic                   issue_valid;
    ID_EX_PACKET            issue_packet;
    logic [ROB_TAG_LEN-1:0] issue_rob_tag;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    reservation_station #(.RS_SIZE(RS)) dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .alloc_enable  (alloc_enable),
        .id_packet_in  (id_packet_in),
        .alloc_rob_tag (alloc_rob_tag),
        .rs1_rob_tag   (rs1_rob_tag),
        .rs2_rob_tag   (rs2_rob_tag),
        .cdb_valid     (cdb_valid),
        .cdb_rob_tag   (cdb_rob_tag),
        .cdb_value     (cdb_value),
        .fu_ready      (fu_ready),
        .rs_full       (rs_full),
        .free_count    (free_count),
        .issue_valid   (issue_valid),
        .issue_packet  (issue_packet),
        .issue_rob_tag (issue_rob_tag)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a slot table; an operand is either ready with a value or waits on a tag (-1 = ready).
    bit          m_used [RS];
    ID_EX_PACKET m_pkt  [RS];
    int          m_dest [RS];
    int          m_w1   [RS];
    int          m_w2   [RS];
    logic [31:0] m_v1   [RS];
    logic [31:0] m_v2   [RS];

    function automatic bit uses_rs1(input ID_EX_PACKET p);
        return p.opa_select == OPA_IS_RS1 || p.cond_branch || p.wr_mem;
    endfunction

    function automatic bit uses_rs2(input ID_EX_PACKET p);
        return p.opb_select == OPB_IS_RS2 || p.cond_branch || p.wr_mem;
    endfunction

    always @(posedge clock) begin : model
        int sel;
        int fr;
        if (reset) begin
            for (int i = 0; i < RS; i++) m_used[i] = 1'b0;
        end else begin
            sel = -1;
            fr  = -1;
            for (int i = RS - 1; i >= 0; i--) begin
                if (m_used[i] && m_w1[i] < 0 && m_w2[i] < 0) sel = i;
                if (!m_used[i]) fr = i;
            end
            if (squash) begin
                for (int i = 0; i < RS; i++) m_used[i] = 1'b0;
            end else begin
                if (cdb_valid) begin
                    for (int i = 0; i < RS; i++) begin
                        if (m_used[i] && m_w1[i] == int'(cdb_rob_tag)) begin m_w1[i] = -1; m_v1[i] = cdb_value; end
                        if (m_used[i] && m_w2[i] == int'(cdb_rob_tag)) begin m_w2[i] = -1; m_v2[i] = cdb_value; end
                    end
                end
                if (sel >= 0 && fu_ready) m_used[sel] = 1'b0;
                if (alloc_enable && id_packet_in.valid && fr >= 0) begin
                    m_used[fr] = 1'b1;
                    m_pkt[fr]  = id_packet_in;
                    m_dest[fr] = int'(alloc_rob_tag);
                    m_v1[fr]   = id_packet_in.rs1_value;
                    m_v2[fr]   = id_packet_in.rs2_value;
                    m_w1[fr]   = -1;
                    m_w2[fr]   = -1;
                    if (uses_rs1(id_packet_in) && rs1_rob_tag != 0) begin
                        if (cdb_valid && cdb_rob_tag == rs1_rob_tag) m_v1[fr] = cdb_value;
                        else m_w1[fr] = int'(rs1_rob_tag);
                    end
                    if (uses_rs2(id_packet_in) && rs2_rob_tag != 0) begin
                        if (cdb_valid && cdb_rob_tag == rs2_rob_tag) m_v2[fr] = cdb_value;
                        else m_w2[fr] = int'(rs2_rob_tag);
                    end
                end
            end
        end
    end

    // Compare every registered-state output against the model mid-cycle.
    always @(negedge clock) begin : compare
        int          nfree;
        int          sel;
        ID_EX_PACKET exp_pkt;
        if (chk_en) begin
            nfree = 0;
            sel   = -1;
            for (int i = RS - 1; i >= 0; i--) begin
                if (!m_used[i]) nfree++;
                if (m_used[i] && m_w1[i] < 0 && m_w2[i] < 0) sel = i;
            end
            exp_pkt = '0;
            if (sel >= 0) begin
                exp_pkt           = m_pkt[sel];
                exp_pkt.rs1_value = m_v1[sel];
                exp_pkt.rs2_value = m_v2[sel];
            end
            check("model free_count", 64'(free_count), 64'(nfree));
            check("model rs_full", 64'(rs_full), 64'(nfree == 0));
            check("model issue_valid", 64'(issue_valid), 64'(sel >= 0));
            check("model issue_rob_tag", 64'(issue_rob_tag), (sel >= 0) ? 64'(m_dest[sel]) : 64'd0);
            tests++;
            if (issue_packet !== exp_pkt) begin
                fails++;
                $display("FAIL model issue_packet: got %h expected %h", issue_packet, exp_pkt);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic ID_EX_PACKET mk(input int kind, input logic [31:0] a, input logic [31:0] b);
        ID_EX_PACKET p;
        p           = '0;
        p.valid     = 1'b1;
        p.rs1_value = a;
        p.rs2_value = b;
        case (kind)
            0: begin p.opa_select = OPA_IS_RS1;  p.opb_select = OPB_IS_I_IMM; p.inst = 32'h00500093; end
            1: begin p.opa_select = OPA_IS_RS1;  p.opb_select = OPB_IS_RS2;   p.inst = 32'h002081b3; end
            default: begin p.opa_select = OPA_IS_ZERO; p.opb_select = OPB_IS_U_IMM; p.inst = 32'h000122b7; end
        endcase
        return p;
    endfunction

    task automatic alloc(input int kind, input logic [31:0] a, input logic [31:0] b,
                         input int dtag, input int t1, input int t2);
        alloc_enable  = 1'b1;
        id_packet_in  = mk(kind, a, b);
        alloc_rob_tag = ROB_TAG_LEN'(dtag);
        rs1_rob_tag   = ROB_TAG_LEN'(t1);
        rs2_rob_tag   = ROB_TAG_LEN'(t2);
        step();
        alloc_enable  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; squash = 1'b0; alloc_enable = 1'b0; id_packet_in = '0;
        alloc_rob_tag = '0; rs1_rob_tag = '0; rs2_rob_tag = '0;
        cdb_valid = 1'b0; cdb_rob_tag = '0; cdb_value = '0; fu_ready = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check("reset rs_full", 64'(rs_full), 64'd0);
        check("reset free_count", 64'(free_count), 64'd8);
        check("reset issue_valid", 64'(issue_valid), 64'd0);
        check("reset issue_rob_tag", 64'(issue_rob_tag), 64'd0);
        check("reset issue_packet.valid", 64'(issue_packet.valid), 64'd0);
        reset = 1'b0;
        step();

        // ADDI with a ready operand issues the cycle after allocation.
        fu_ready = 1'b1;
        alloc(0, 32'd5, 32'd0, 3, 0, 0);
        check("addi issue_valid", 64'(issue_valid), 64'd1);
        check("addi issue_rob_tag", 64'(issue_rob_tag), 64'd3);
        check("addi rs1_value", 64'(issue_packet.rs1_value), 64'd5);
        step();
        check("addi freed", 64'(free_count), 64'd8);

        // ADD waiting on tag 4, woken three cycles later.
        alloc(1, 32'd0, 32'd1, 8, 4, 0);
        check("add waiting", 64'(issue_valid), 64'd0);
        step();
        step();
        cdb_valid = 1'b1; cdb_rob_tag = 5'd4; cdb_value = 32'hDEAD;
        step();
        cdb_valid = 1'b0;
        check("add woken valid", 64'(issue_valid), 64'd1);
        check("add woken rs1_value", 64'(issue_packet.rs1_value), 64'hDEAD);
        step();

        // Same-cycle CDB bypass at allocation.
        cdb_valid = 1'b1; cdb_rob_tag = 5'd6; cdb_value = 32'd9;
        alloc(1, 32'd1, 32'd0, 9, 0, 6);
        cdb_valid = 1'b0;
        check("bypass issue_valid", 64'(issue_valid), 64'd1);
        check("bypass rs2_value", 64'(issue_packet.rs2_value), 64'd9);
        step();

        // Invalid packet is never allocated.
        alloc_enable = 1'b1; id_packet_in = '0; alloc_rob_tag = 5'd30;
        step();
        alloc_enable = 1'b0;
        check("invalid not allocated", 64'(free_count), 64'd8);

        // Fill with eight waiters on tag 7, drop a ninth, then drain in index order.
        for (int k = 0; k < 8; k++) alloc(1, 32'd0, 32'd0, 10 + k, 7, 7);
        check("full rs_full", 64'(rs_full), 64'd1);
        check("full free_count", 64'(free_count), 64'd0);
        alloc(0, 32'd1, 32'd0, 20, 0, 0);
        check("ninth ignored", 64'(free_count), 64'd0);
        cdb_valid = 1'b1; cdb_rob_tag = 5'd7; cdb_value = 32'h77;
        step();
        cdb_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("drain issue_rob_tag", 64'(issue_rob_tag), 64'(10 + k));
            check("drain rs2_value", 64'(issue_packet.rs2_value), 64'h77);
            step();
        end
        check("drained", 64'(free_count), 64'd8);

        // Back-to-back allocation alongside dispatch.
        alloc(0, 32'd11, 32'd0, 21, 0, 0);
        alloc(0, 32'd12, 32'd0, 22, 0, 0);
        check("b2b second tag", 64'(issue_rob_tag), 64'd22);
        step();

        // Fill, then squash concurrent with allocation and a possible dispatch.
        fu_ready = 1'b0;
        for (int k = 0; k < 8; k++) alloc(0, 32'(k), 32'd0, k + 1, 0, 0);
        check("prefill full", 64'(rs_full), 64'd1);
        squash = 1'b1; fu_ready = 1'b1;
        alloc(0, 32'd3, 32'd0, 25, 0, 0);
        squash = 1'b0;
        check("squash free_count", 64'(free_count), 64'd8);
        check("squash issue_valid", 64'(issue_valid), 64'd0);

        // LUI ignores its operand tags.
        alloc(2, 32'd0, 32'd0, 13, 2, 5);
        check("lui issue_valid", 64'(issue_valid), 64'd1);
        check("lui issue_rob_tag", 64'(issue_rob_tag), 64'd13);
        step();

        // Reset mid-operation discards held entries.
        alloc(1, 32'd0, 32'd0, 14, 3, 3);
        alloc(1, 32'd0, 32'd0, 15, 3, 3);
        check("pre-reset free_count", 64'(free_count), 64'd6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid reset free_count", 64'(free_count), 64'd8);
        check("mid reset issue_valid", 64'(issue_valid), 64'd0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
